// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save resolve stage.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } csa_resolve_state_t;

  // Number of seg_len-bit segments needed to cover out_len bits.
  function automatic int unsigned num_segs(input int unsigned out_len,
                                           input int unsigned seg_len);
    return (out_len + seg_len - 1) / seg_len;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/segment_adder.sv
// SEG_LEN-bit ripple-carry adder built from full_adder cells.
module segment_adder #(
  parameter int unsigned SEG_LEN = 8
) (
  input  logic [SEG_LEN-1:0] a,
  input  logic [SEG_LEN-1:0] b,
  input  logic               cin,
  output logic [SEG_LEN-1:0] sum,
  output logic               cout
);

  logic [SEG_LEN:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < SEG_LEN; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[SEG_LEN];

endmodule

// File: rtl/csa_resolve.sv
// Resolves a carry-save pair (S, C) into S + 2*C, one SEG_LEN-bit segment per clock.
module csa_resolve
  import csa_pkg::*;
#(
  parameter int unsigned BIT_LEN = 19,
  parameter int unsigned SEG_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_LEN-1:0]   in_s,
  input  logic [BIT_LEN-1:0]   in_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_LEN+1:0]   out_sum
);

  localparam int unsigned OUT_LEN  = BIT_LEN + 2;
  localparam int unsigned NUM_SEGS = num_segs(OUT_LEN, SEG_LEN);
  localparam int unsigned IDX_W    = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
  localparam int unsigned NUM_SLOT = 1 << IDX_W;
  localparam int unsigned PAD_LEN  = NUM_SLOT * SEG_LEN;
  localparam logic [IDX_W-1:0] LAST_SEG = IDX_W'(NUM_SEGS - 1);

  csa_resolve_state_t state_q, state_d;
  logic [IDX_W-1:0]   seg_q, seg_d;
  logic               carry_q, carry_d;
  logic [BIT_LEN-1:0] s_q, s_d;
  logic [BIT_LEN-1:0] c_q, c_d;
  logic [OUT_LEN-1:0] sum_q, sum_d;
  logic               out_valid_q, out_valid_d;

  // Operands zero-padded to a whole number of segment slots.
  logic [PAD_LEN-1:0] a_pad, b_pad;
  logic [SEG_LEN-1:0] a_seg [NUM_SLOT];
  logic [SEG_LEN-1:0] b_seg [NUM_SLOT];
  logic [SEG_LEN-1:0] seg_a, seg_b, seg_sum;
  logic               seg_cout;
  logic [OUT_LEN-1:0] wr_mask, wr_data;

  assign a_pad = PAD_LEN'(s_q);
  assign b_pad = PAD_LEN'({c_q, 1'b0});

  for (genvar g = 0; g < NUM_SLOT; g++) begin : g_slot
    assign a_seg[g] = a_pad[g*SEG_LEN +: SEG_LEN];
    assign b_seg[g] = b_pad[g*SEG_LEN +: SEG_LEN];
  end

  assign seg_a = a_seg[seg_q];
  assign seg_b = b_seg[seg_q];

  segment_adder #(
    .SEG_LEN (SEG_LEN)
  ) u_seg_add (
    .a    (seg_a),
    .b    (seg_b),
    .cin  (carry_q),
    .sum  (seg_sum),
    .cout (seg_cout)
  );

  // Steer the segment result onto its bit range; bits past OUT_LEN-1 are dropped.
  for (genvar g = 0; g < NUM_SEGS; g++) begin : g_wr
    localparam int unsigned LO = g * SEG_LEN;
    localparam int unsigned HI = ((LO + SEG_LEN) < OUT_LEN) ? (LO + SEG_LEN - 1) : (OUT_LEN - 1);
    localparam int unsigned W  = HI - LO + 1;
    assign wr_mask[HI:LO] = {W{seg_q == IDX_W'(g)}};
    assign wr_data[HI:LO] = seg_sum[W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    carry_d     = carry_q;
    s_d         = s_q;
    c_d         = c_q;
    sum_d       = sum_q;
    in_ready    = 1'b0;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      ADD: begin
        sum_d   = (sum_q & ~wr_mask) | (wr_data & wr_mask);
        carry_d = seg_cout;
        if (seg_q == LAST_SEG) begin
          state_d = HOLD;
        end else begin
          seg_d = seg_q + IDX_W'(1);
        end
      end
      HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accept overrides any exit taken above, including HOLD -> IDLE.
    if (in_valid && in_ready) begin
      s_d     = in_s;
      c_d     = in_c;
      seg_d   = '0;
      carry_d = 1'b0;
      state_d = ADD;
    end

    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      seg_q       <= '0;
      carry_q     <= 1'b0;
      s_q         <= '0;
      c_q         <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      carry_q     <= carry_d;
      s_q         <= s_d;
      c_q         <= c_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;

endmodule

// File: tb/tb_csa_resolve.sv
// Directed and streaming scoreboard bench for csa_resolve.
module tb_csa_resolve;

  localparam int unsigned BIT_LEN = 19;
  localparam int unsigned OUT_LEN = 21;
  localparam int unsigned EXP_LAT = 3;
  localparam int unsigned EXP_GAP = 4;
  localparam int unsigned N_STREAM = 1000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic [BIT_LEN-1:0] in_s = '0;
  logic [BIT_LEN-1:0] in_c = '0;
  logic               in_ready;
  logic               out_valid;
  logic [OUT_LEN-1:0] out_sum;

  int total = 0;
  int bad = 0;
  logic [OUT_LEN-1:0] sb_q[$];

  csa_resolve dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_LEN-1:0] model(input logic [BIT_LEN-1:0] s,
                                               input logic [BIT_LEN-1:0] c);
    return {2'b00, s} + {1'b0, c, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a pair, wait for the accept edge, and record the expected result.
  task automatic send(input logic [BIT_LEN-1:0] s, input logic [BIT_LEN-1:0] c,
                      input string tag);
    int n = 0;
    in_s = s;
    in_c = c;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    step();
    sb_q.push_back(model(s, c));
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge to out_valid and compare with the scoreboard.
  task automatic wait_result(input string tag);
    int lat = 0;
    logic [OUT_LEN-1:0] e = 'x;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(EXP_LAT));
    if (sb_q.size() > 0) e = sb_q.pop_front();
    check({tag, "_sum"}, 32'(out_sum), 32'(e));
  endtask

  initial begin
    logic [OUT_LEN-1:0] held;
    logic [OUT_LEN-1:0] e;
    int sent, got, cyc, last;
    logic acc, fire;

    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_sum", 32'(out_sum), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    out_ready = 1'b1;
    send(19'h00005, 19'h00003, "basic");
    wait_result("basic");
    check("basic_value", 32'(out_sum), 32'h00000B);
    step();
    check("basic_release", 32'(out_valid), 32'(0));

    send(19'h7FFFF, 19'h7FFFF, "max");
    wait_result("max");
    check("max_value", 32'(out_sum), 32'h17FFFD);
    step();

    send(19'h000FF, 19'h00001, "cross");
    wait_result("cross");
    check("cross_value", 32'(out_sum), 32'h000101);
    step();

    out_ready = 1'b0;
    send(19'h12345, 19'h0ABCD, "bp_a");
    wait_result("bp_a");
    held = out_sum;
    in_s = 19'h55555;
    in_c = 19'h2AAAA;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_sum", 32'(out_sum), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_out_valid", 32'(out_valid), 32'(1));
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'(1));
    step();
    sb_q.push_back(model(19'h55555, 19'h2AAAA));
    in_valid = 1'b0;
    check("bp_accepted", 32'(out_valid), 32'(0));
    wait_result("bp_b");
    step();

    send(19'h00001, 19'h00001, "rst");
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'(0));
    check("rst_mid_out_sum", 32'(out_sum), 32'(0));
    check("rst_mid_in_ready", 32'(in_ready), 32'(1));
    void'(sb_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_quiet", 32'(out_valid), 32'(0));
    end
    send(19'h00ABC, 19'h00123, "post_rst");
    wait_result("post_rst");
    step();

    sent = 0;
    got = 0;
    cyc = 0;
    last = -1;
    out_ready = 1'b1;
    in_s = 19'($urandom);
    in_c = 19'($urandom);
    in_valid = 1'b1;
    while (got < int'(N_STREAM) && cyc < 6000) begin
      acc = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        e = 'x;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        check("stream_sum", 32'(out_sum), 32'(e));
        if (last >= 0) check("stream_gap", 32'(cyc - last), 32'(EXP_GAP));
        last = cyc;
        got++;
      end
      if (acc) begin
        sb_q.push_back(model(in_s, in_c));
        sent++;
      end
      step();
      cyc++;
      if (acc) begin
        if (sent < int'(N_STREAM)) begin
          in_s = 19'($urandom);
          in_c = 19'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("stream_count", 32'(got), 32'(N_STREAM));
    check("stream_drained", 32'(sb_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csa_resolve.md
# csa_resolve

Sequential carry-propagate stage placed directly downstream of `carry_save_adder`. It accepts one redundant pair per transaction: the sum vector `S` and the carry vector `C`, where `C[i]` has weight 2^(i+1). It produces the binary value S + 2·C. The addition is done as a ripple over `SEG_LEN`-bit segments, one segment per clock, so wide CSA trees do not need a full-width single-cycle adder.

## Interface
- `BIT_LEN`, 19, width of the incoming `S` and `C` vectors.
- `SEG_LEN`, 8, bits resolved per clock; legal range 1..`OUT_LEN`.
- `OUT_LEN`, derived, equals `BIT_LEN`+2; the value is not overridable.
- `NUM_SEGS`, derived, equals ceil(`OUT_LEN`/`SEG_LEN`).

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  the `in_s`/`in_c` pair is valid.
- `in_ready`  out  1  the block accepts the pair this cycle.
- `in_s`  in  `BIT_LEN`  sum vector from the CSA.
- `in_c`  in  `BIT_LEN`  carry vector from the CSA, unshifted.
- `out_valid`  out  1  `out_sum` is valid.
- `out_ready`  in  1  the consumer takes `out_sum` this cycle.
- `out_sum`  out  `OUT_LEN`  the binary value S + 2·C.

## Operation
- States:
  - IDLE: no transaction held.
  - ADD: segments are being resolved.
  - HOLD: the result is presented on the output.
- Reset state: IDLE, with `out_valid`=0, `out_sum`=0, segment index=0, carry=0. `in_ready` reads 1 as soon as the state is IDLE.
- `in_ready` = (IDLE) or (HOLD and `out_ready`).
- `out_valid` = HOLD.
- Accept happens on a rising edge where `in_valid` and `in_ready` are both high. On accept:
  - operand A ← {2'b0, `in_s`}.
  - operand B ← {1'b0, `in_c`, 1'b0}.
  - segment index ← 0, carry ← 0, state → ADD.
- Each edge in ADD:
  - adds segment k of A, segment k of B and the carry.
  - writes the segment result into bits [k·SEG_LEN +: SEG_LEN] of `out_sum`.
  - registers the segment carry-out.
  - increments k.
- Final segment:
  - when k = `NUM_SEGS`-1, state → HOLD.
  - bits above `OUT_LEN`-1 are discarded.
  - the carry-out of the final segment is discarded; it is provably zero because the maximum sum is 3·(2^BIT_LEN − 1).
- `out_sum` upper bits still pending are undefined until HOLD; verification compares only in HOLD.
- HOLD exits:
  - `out_ready`=1 and `in_valid`=0: → IDLE.
  - `out_ready`=1 and `in_valid`=1: accept the new pair and → ADD in the same edge.
  - `out_ready`=0: stay in HOLD with `out_sum` frozen; `in_ready`=0.
- `in_valid` while in ADD is ignored; nothing is accepted and nothing is dropped.
- `rst_n` falling mid-ADD or mid-HOLD aborts the transaction immediately. The pending result is lost and not presented after reset release.

## Timing
- Latency: `out_valid` rises `NUM_SEGS` edges after the accept edge. For the defaults that is 3 edges.
- Sustained throughput: one result per `NUM_SEGS`+1 cycles when `out_ready` is held high.
- `in_ready` depends combinationally on `out_ready` in HOLD only. There is no other combinational input-to-output path.
- `out_sum` and `out_valid` are driven directly from registers.

## Structure
- Shared package `csa_pkg`:
  - state typedef `csa_resolve_state_t` {IDLE, ADD, HOLD}.
  - function `num_segs(out_len, seg_len)`.
- One sub-module, `segment_adder`:
  - parameter `SEG_LEN`; inputs a, b, cin; outputs sum, cout.
  - built as a ripple of the existing `full_adder`.
  - instantiated once and muxed by segment index.
- The top level holds the FSM, the operand registers, the segment counter, the carry register and the result register.

## Test plan
All scenarios use defaults `BIT_LEN`=19, `SEG_LEN`=8, so `NUM_SEGS`=3.
- Basic: S=0x00005, C=0x00003 → `out_sum`=0x00000B; `out_valid` is high exactly 3 edges after the accept edge.
- Maximum values: S=0x7FFFF, C=0x7FFFF → `out_sum`=0x17FFFD, with no overflow and no X on any bit.
- Cross-segment carry: S=0x000FF, C=0x00001 → `out_sum`=0x000101 (carry ripples from segment 0 into segment 1).
- Backpressure: hold `out_ready`=0 for 10 cycles in HOLD while `in_valid`=1 with new data.
  - `out_sum` stays stable and `in_ready` stays 0.
  - Releasing `out_ready` accepts the new pair in that same edge.
- Reset mid-ADD: assert `rst_n`=0 one cycle after accept.
  - All outputs return to their reset values asynchronously.
  - After release, `out_valid` stays 0 until a fresh transaction completes.
- Back-to-back random stream: 1000 pairs with `out_ready` held high.
  - A result is produced every 4 cycles.
  - Every result equals S + 2·C from the reference model, in order.
